// File: rtl/asrm_ram_responder.sv
// asrm_ram_responder: memory behind the ASRM CPU RAM port.
// A single-port word array with a two-stage registered read (write-first on
// a same-edge write), sticky out-of-range detection, and an optional
// post-reset zero-fill sequencer enabled by defining ASRM_RAM_CLEAR_EN.
// Without ASRM_RAM_CLEAR_EN, busy is tied low and contents survive reset.
module asrm_ram_responder #(
  parameter int wordsize   = 16,
  parameter int addr_width = 10
) (
  input  logic                clk,
  input  logic                reset,        // synchronous, active-low
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                busy,
  output logic                addr_err
);

  localparam int DEPTH = 1 << addr_width;

  logic [wordsize-1:0]   mem [DEPTH];
  logic [wordsize-1:0]   rd_q;
  logic [wordsize-1:0]   rdata_q;
  logic                  addr_err_q;

  logic                  in_range;
  logic                  clearing;
  logic [addr_width-1:0] word_addr;
  logic                  mem_we;
  logic [addr_width-1:0] mem_waddr;
  logic [wordsize-1:0]   mem_wdata;

  assign word_addr = cpu_addr[addr_width-1:0];

  // An address is legal only when every bit above the implemented range is 0.
  generate
    if (addr_width < wordsize) begin : g_range_check
      assign in_range = ~|cpu_addr[wordsize-1:addr_width];
    end else begin : g_range_full
      assign in_range = 1'b1;
    end
  endgenerate

`ifdef ASRM_RAM_CLEAR_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // One extra counter bit so the terminal compare never wraps to 0.
  localparam logic [addr_width:0] CNT_LAST = (addr_width+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [addr_width:0] cnt_q, cnt_d;

  // State register: every reset restarts the zero-fill from word 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk the counter through the array, leave CLEAR on the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign clearing  = (state_q == ST_CLEAR);
  // The sequencer owns the write port while clearing; CPU writes are ignored.
  assign mem_we    = reset && (clearing || (cpu_write_en && in_range));
  assign mem_waddr = clearing ? cnt_q[addr_width-1:0] : word_addr;
  assign mem_wdata = clearing ? '0 : cpu_wdata;
`else
  assign clearing  = 1'b0;
  assign mem_we    = reset && cpu_write_en && in_range;
  assign mem_waddr = word_addr;
  assign mem_wdata = cpu_wdata;
`endif

  // Array write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read stage 1: capture every edge, write-first when the CPU writes this word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= '0;
    end else if (clearing || !in_range) begin
      rd_q <= '0;
    end else if (cpu_write_en) begin
      rd_q <= cpu_wdata;
    end else begin
      rd_q <= mem[word_addr];
    end
  end

  // Read stage 2: output register, held at 0 while the array is being cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (clearing) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_q;
    end
  end

  // Sticky out-of-range flag; only a reset clears it, clearing does not update it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_err_q <= 1'b0;
    end else if (!clearing && !in_range) begin
      addr_err_q <= 1'b1;
    end
  end

  assign cpu_rdata = rdata_q;
  assign addr_err  = addr_err_q;
  assign busy      = clearing;

endmodule

// File: tb/tb_asrm_ram_responder.sv
// Scoreboard bench for asrm_ram_responder: the driver pushes the expected read
// data for every issued access; a monitor pops and compares as data emerges.
`timescale 1ns/1ps
module tb_asrm_ram_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_write_en = 1'b0;
  logic [15:0] cpu_rdata;
  logic        busy;
  logic        addr_err;

  asrm_ram_responder #(.wordsize(16), .addr_width(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_write_en (cpu_write_en),
    .cpu_rdata    (cpu_rdata),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          edge_count = 0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: plain word array, sticky error bit, remaining clear cycles.
  logic [15:0] model [DEPTH];
  logic        err_model = 1'b0;
  int          clr_left = 0;

  always @(posedge clk) edge_count <= edge_count + 1;

  // Monitor: read data for an access sampled at edge N is due after edge N+1.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= edge_count) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.due != edge_count || cpu_rdata !== mon_e.val) begin
        errors++;
        $display("FAIL rdata addr=%h edge=%0d due=%0d got=%h exp=%h",
                 mon_e.addr, edge_count, mon_e.due, cpu_rdata, mon_e.val);
      end else begin
        $display("txn edge=%0d addr=%h rdata=%h", edge_count, mon_e.addr, cpu_rdata);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", name, edge_count, got, exp);
    end
  endtask

  // Enter and leave at a falling edge; one access per call.
  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we);
    exp_t e;
    reset        = 1'b1;
    cpu_addr     = a;
    cpu_wdata    = d;
    cpu_write_en = we;
    e.due  = edge_count + 2;
    e.addr = a;
    if (clr_left > 0) begin
      e.val = '0;
      clr_left--;
    end else if (a >= 16'(DEPTH)) begin
      e.val     = '0;
      err_model = 1'b1;
    end else if (we) begin
      e.val = d;
      model[a[9:0]] = d;
    end else begin
      e.val = model[a[9:0]];
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check("addr_err", {15'b0, addr_err}, {15'b0, err_model});
    check("busy", {15'b0, busy}, {15'b0, clr_left > 0});
  endtask

  task automatic drain();
    int guard;
    guard        = 0;
    cpu_write_en = 1'b0;
    cpu_addr     = '0;
    while (sb.size() > 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rst(input int n);
    drain();
    reset        = 1'b0;
    cpu_write_en = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    err_model = 1'b0;
`ifdef ASRM_RAM_CLEAR_EN
    clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    check("rst_rdata", cpu_rdata, 16'h0000);
    check("rst_addr_err", {15'b0, addr_err}, 16'h0000);
    check("rst_busy", {15'b0, busy}, {15'b0, clr_left > 0});
  endtask

  initial begin
    @(negedge clk);
    rst(3);
`ifdef ASRM_RAM_CLEAR_EN
    // Initial zero-fill; CPU writes issued meanwhile must be ignored.
    for (int i = 0; i < DEPTH; i++)
      drive(16'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'($urandom_range(0, 1)));
`else
    for (int i = 0; i < DEPTH; i++) drive(16'(i), 16'($urandom), 1'b1);
`endif

    // Write then read back.
    drive(16'h0005, 16'hBEEF, 1'b1);
    drive(16'h0005, 16'h0000, 1'b0);
    // Bypass: old value 0xAAAA, same-edge write 0x1234 must be seen.
    drive(16'h0007, 16'hAAAA, 1'b1);
    drive(16'h0020, 16'h0000, 1'b0);
    drive(16'h0007, 16'h1234, 1'b1);
    drive(16'h0007, 16'h0000, 1'b0);
    // Captured read not disturbed by a write on the following edge.
    drive(16'h0020, 16'h0000, 1'b0);
    drive(16'h0020, 16'h7777, 1'b1);
    drive(16'h0020, 16'h0000, 1'b0);
    // Out of range: dropped write, zero read, sticky flag, mem[0] intact.
    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'h0400, 16'h5555, 1'b1);
    drive(16'h0400, 16'h0000, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'hFFFF, 16'h0000, 1'b0);
    drive(16'h0001, 16'h0000, 1'b0);

    // Randomised traffic, mostly a small address window to force reuse.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 16'($urandom) | 16'h0400;
      else if (r < 7)  a = 16'($urandom_range(0, 31));
      else             a = 16'($urandom_range(0, DEPTH - 1));
      drive(a, 16'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef ASRM_RAM_CLEAR_EN
    // Fill with 0xFFFF, reset, and check the full clear window.
    for (int i = 0; i < DEPTH; i++) drive(16'(i), 16'hFFFF, 1'b1);
    rst(2);
    for (int i = 0; i < DEPTH; i++)
      drive(16'($urandom_range(0, DEPTH - 1)), 16'hFFFF, 1'($urandom_range(0, 1)));
    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'h01FF, 16'h0000, 1'b0);
    drive(16'h03FF, 16'h0000, 1'b0);
    // Reset at counter 300 restarts a full clear.
    for (int i = 0; i < DEPTH; i++) drive(16'(i), 16'hFFFF, 1'b1);
    rst(2);
    for (int i = 0; i < 300; i++) drive(16'(i), 16'h0000, 1'b0);
    rst(1);
    for (int i = 0; i < DEPTH; i++) drive(16'h0003, 16'hFFFF, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(16'(i), 16'h0000, 1'b0);
`else
    // Contents survive reset and service resumes immediately.
    drive(16'h0010, 16'h00C3, 1'b1);
    rst(2);
    drive(16'h0010, 16'h0000, 1'b0);
    drive(16'h0010, 16'h0000, 1'b0);
    drive(16'h0005, 16'h0000, 1'b0);
`endif

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
